sel_ctrl: RTL and testbench
===========================

# sel_ctrl

Selection controller for the 24-game play field. It turns debounced button pulses into a cursor and the two operand selections (`s1`/`s2`, format `{valid, pos[1:0]}`) consumed by the screen renderer. It issues a combine request to the arithmetic unit over a req/ack handshake and tracks which of the four number positions have been consumed. Display-facing outputs change only at frame boundaries, so a frame never shows a half-updated selection.

## Interface

Parameters:
- `NPOS`, 4: number of operand positions; must be 4 (2-bit position encoding).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `frame_start`  in  1  one-cycle pulse at start of each VGA frame
- `btn_next`  in  1  one-cycle pulse: advance cursor
- `btn_sel`  in  1  one-cycle pulse: select, deselect or commit at cursor
- `btn_clr`  in  1  one-cycle pulse: drop current selections
- `new_game`  in  1  one-cycle pulse: clear used mask, restart
- `op_in`  in  2  operator chosen by user (+,-,*,/ = 0..3)
- `req`  out  1  combine request to arithmetic unit
- `a_pos`, `b_pos`  out  2 each  operand positions for request
- `op`  out  2  latched operator for request
- `ack`  in  1  one-cycle pulse: arithmetic unit has written the result into `b_pos`
- `cursor`  out  2  cursor position (frame-synchronous)
- `s1`, `s2`  out  3 each  `{valid,pos}` selections to renderer (frame-synchronous)
- `used`  out  4  consumed-position mask, bit i = position i
- `done`  out  1  exactly one position remains unused

## Operation

- FSM states:
  - IDLE: no selection.
  - FIRST: `s1` valid.
  - SECOND: `s1` and `s2` valid.
  - REQ: waiting for `ack`.
- Input priority when pulses coincide: `new_game` > `btn_clr` > `btn_sel` > `btn_next`. Only the highest-priority pulse acts in a cycle.
- `btn_next` in IDLE, FIRST or SECOND: cursor moves to the next position with `used`=0, searching `cursor+1, +2, +3` mod 4. If none is found, the cursor stays.
- `btn_sel`:
  - IDLE: `s1`←`{1,cursor}`, go to FIRST.
  - FIRST, cursor==`s1.pos`: deselect, go to IDLE.
  - FIRST, cursor≠`s1.pos`: `s2`←`{1,cursor}`, go to SECOND.
  - SECOND: latch `op`←`op_in`, `a_pos`←`s1.pos`, `b_pos`←`s2.pos`, assert `req`, go to REQ.
- `btn_clr` in FIRST or SECOND: both selections invalid, go to IDLE. Ignored in IDLE and REQ.
- REQ: `btn_next`, `btn_sel` and `btn_clr` are ignored. `req` stays high until the cycle `ack` is sampled high.
- On `ack`:
  - `used[a_pos]`←1.
  - Selections invalid.
  - cursor←`b_pos`.
  - `req`←0, go to IDLE.
- `ack` outside REQ is ignored.
- `new_game` from any state: `used`←0, selections invalid, cursor←0, `req`←0, go to IDLE. A request outstanding at that moment is abandoned; a later stray `ack` is ignored.
- `done` = popcount(`used`)==3. While `done`=1, `btn_sel` and `btn_next` are ignored until `new_game`.

## Timing

- Reset values: state IDLE; `req`=0, `a_pos`=`b_pos`=`op`=0, `used`=0, `done`=0, `cursor`=0, `s1`=`s2`=3'b000. Internal shadow state resets to the same values.
- State, `req`, `a_pos`, `b_pos`, `op`, `used` and `done` update on the clock edge that samples the pulse (1-cycle latency).
- `cursor`, `s1` and `s2` are display copies loaded from internal shadow state on the edge where `frame_start`=1. If a pulse and `frame_start` occur in the same cycle, the display copy takes the pre-pulse shadow value; the new value appears at the next `frame_start`.
- `req` may fall in the same cycle as `ack`'s edge. A new `req` cannot rise sooner than two user actions later.

## Structure

- Shared package `game_pkg`:
  - `POS_W`=2.
  - Operator encodings `OP_ADD`..`OP_DIV`.
  - State enum values.
  - Selection-field layout: bit 2 valid, bits 1:0 pos.
- Sub-module `next_free_pos`: combinational. Inputs cursor and `used`; outputs the next free position and a found flag. Reused later by the hint logic.

## Test plan

- Reset, then `frame_start`: `s1`=`s2`=0, `cursor`=0, `req`=0, `used`=0.
- `btn_next`×2, `btn_sel`, `btn_next`, `btn_sel`, `frame_start`: `s1`=3'b110, `s2`=3'b111; before `frame_start` both still read 0.
- From SECOND with `op_in`=2, `btn_sel`: `req`=1, `a_pos`=2, `b_pos`=3, `op`=2. Hold `req` for 5 cycles, pulse `ack`: `used`=4'b0100, next-frame `cursor`=3, state IDLE.
- Select pos 0, then `btn_sel` again at pos 0: back to IDLE, `s1` invalid after `frame_start`. `btn_clr` and `btn_sel` in the same cycle from SECOND: clear wins, no `req`.
- Three combines until `used`=4'b0111: `done`=1, `btn_next` leaves cursor at 3. `new_game` during a pending `req`: `req`=0, `used`=0, and a following `ack` changes nothing.
- `rst_n` asserted mid-REQ, asynchronously between clock edges: all outputs return to reset values immediately.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the 24-game play field
// Purpose: position width, operator encodings, controller states, selection
// field layout and small mask helpers shared by the selection logic.
// Ports: none (package).
package game_pkg;

  localparam int POS_W         = 2;
  localparam int NUM_POS       = 4;
  localparam int SEL_W         = 3;
  localparam int SEL_VALID_BIT = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_REQ    = 2'd3
  } state_e;

  // Selection field seen by the renderer: bit 2 valid, bits 1:0 position.
  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] pos;
  } sel_t;

  function automatic logic [NUM_POS-1:0] pos_mask(input logic [POS_W-1:0] p);
    logic [NUM_POS-1:0] m;
    m    = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] popcount(input logic [NUM_POS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_POS; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/next_free_pos.sv
// rtl/next_free_pos.sv - finds the nearest unused position after the cursor
// Purpose: combinational search of cur+1, cur+2, cur+3 (mod 4) for a clear
// bit in the used mask.
// Ports: cur_i (current position), used_i (consumed mask),
//        pos_o (next free position, cur_i when none), found_o (a free one exists).
module next_free_pos
  import game_pkg::*;
(
  input  logic [POS_W-1:0]   cur_i,
  input  logic [NUM_POS-1:0] used_i,
  output logic [POS_W-1:0]   pos_o,
  output logic               found_o
);

  logic [POS_W-1:0] cand;

  // Walk farthest to nearest so the nearest free position is the last write.
  always_comb begin
    pos_o   = cur_i;
    found_o = 1'b0;
    cand    = cur_i;
    for (int k = NUM_POS - 1; k >= 1; k--) begin
      cand = cur_i + k[POS_W-1:0];
      if (!used_i[cand]) begin
        pos_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_ctrl.sv
// rtl/sel_ctrl.sv - cursor/operand selection controller with combine handshake
// Purpose: turns button pulses into cursor and two operand selections, issues
// a combine request over req/ack and tracks consumed positions.
// Ports: clk, rst_n (async active-low); frame_start, btn_next, btn_sel,
//        btn_clr, new_game, op_in, ack (inputs); req, a_pos, b_pos, op, used,
//        done (clock-edge outputs); cursor, s1, s2 (frame-synchronous copies).
module sel_ctrl
  import game_pkg::*;
#(
  parameter int NPOS = 4  // 2-bit position encoding only supports 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             btn_next,
  input  logic             btn_sel,
  input  logic             btn_clr,
  input  logic             new_game,
  input  logic [1:0]       op_in,
  output logic             req,
  output logic [POS_W-1:0] a_pos,
  output logic [POS_W-1:0] b_pos,
  output logic [1:0]       op,
  input  logic             ack,
  output logic [POS_W-1:0] cursor,
  output logic [SEL_W-1:0] s1,
  output logic [SEL_W-1:0] s2,
  output logic [NPOS-1:0]  used,
  output logic             done
);

  state_e           state_q;
  logic             req_q;
  logic [POS_W-1:0] a_pos_q, b_pos_q;
  op_e              op_q;
  logic [NPOS-1:0]  used_q;
  logic             done_q;

  // Shadow copies updated immediately; display copies follow on frame_start.
  logic [POS_W-1:0] cur_q;
  sel_t             s1_q, s2_q;
  logic [POS_W-1:0] cur_disp_q;
  sel_t             s1_disp_q, s2_disp_q;

  logic [POS_W-1:0] nf_pos;
  logic             nf_found;
  logic [NPOS-1:0]  used_ack_d;

  next_free_pos u_next_free_pos (
    .cur_i   (cur_q),
    .used_i  (used_q),
    .pos_o   (nf_pos),
    .found_o (nf_found)
  );

  assign used_ack_d = used_q | pos_mask(a_pos_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      a_pos_q    <= '0;
      b_pos_q    <= '0;
      op_q       <= OP_ADD;
      used_q     <= '0;
      done_q     <= 1'b0;
      cur_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      cur_disp_q <= '0;
      s1_disp_q  <= '0;
      s2_disp_q  <= '0;
    end else begin
      // Captures the pre-edge shadow, so a coincident pulse shows next frame.
      if (frame_start) begin
        cur_disp_q <= cur_q;
        s1_disp_q  <= s1_q;
        s2_disp_q  <= s2_q;
      end

      if (new_game) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
        used_q  <= '0;
        done_q  <= 1'b0;
        cur_q   <= '0;
        s1_q    <= '0;
        s2_q    <= '0;
      end else begin
        case (state_q)
          ST_REQ: begin
            if (ack) begin
              used_q  <= used_ack_d;
              done_q  <= (popcount(used_ack_d) == 3'd3);
              s1_q    <= '0;
              s2_q    <= '0;
              cur_q   <= b_pos_q;  // result lives in b_pos
              req_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            // Strict priority: a clear in IDLE still swallows sel/next.
            if (btn_clr) begin
              if (state_q != ST_IDLE) begin
                s1_q    <= '0;
                s2_q    <= '0;
                state_q <= ST_IDLE;
              end
            end else if (btn_sel && !done_q) begin
              case (state_q)
                ST_IDLE: begin
                  s1_q    <= '{valid: 1'b1, pos: cur_q};
                  state_q <= ST_FIRST;
                end
                ST_FIRST: begin
                  if (cur_q == s1_q.pos) begin
                    s1_q    <= '0;
                    state_q <= ST_IDLE;
                  end else begin
                    s2_q    <= '{valid: 1'b1, pos: cur_q};
                    state_q <= ST_SECOND;
                  end
                end
                ST_SECOND: begin
                  op_q    <= op_e'(op_in);
                  a_pos_q <= s1_q.pos;
                  b_pos_q <= s2_q.pos;
                  req_q   <= 1'b1;
                  state_q <= ST_REQ;
                end
                default: ;
              endcase
            end else if (btn_next && !done_q && nf_found) begin
              cur_q <= nf_pos;
            end
          end
        endcase
      end
    end
  end

  assign req    = req_q;
  assign a_pos  = a_pos_q;
  assign b_pos  = b_pos_q;
  assign op     = op_q;
  assign used   = used_q;
  assign done   = done_q;
  assign cursor = cur_disp_q;
  assign s1     = s1_disp_q;
  assign s2     = s2_disp_q;

endmodule

// File: tb/tb_sel_ctrl.sv
// tb/tb_sel_ctrl.sv - self-checking bench for sel_ctrl
module tb_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start, btn_next, btn_sel, btn_clr, new_game, ack;
  logic [1:0] op_in;
  logic       req;
  logic [1:0] a_pos, b_pos, op, cursor;
  logic [2:0] s1, s2;
  logic [3:0] used;
  logic       done;

  int checks = 0;
  int errors = 0;

  sel_ctrl #(.NPOS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .btn_next    (btn_next),
    .btn_sel     (btn_sel),
    .btn_clr     (btn_clr),
    .new_game    (new_game),
    .op_in       (op_in),
    .req         (req),
    .a_pos       (a_pos),
    .b_pos       (b_pos),
    .op          (op),
    .ack         (ack),
    .cursor      (cursor),
    .s1          (s1),
    .s2          (s2),
    .used        (used),
    .done        (done)
  );

  always #5 clk = ~clk;

  // pulses = {new_game, btn_clr, btn_sel, btn_next, frame_start, ack}
  typedef struct {
    logic [5:0] pulses;
    logic [1:0] opi;
    logic       req;
    logic [1:0] a, b, op, cur;
    logic [2:0] s1, s2;
    logic [3:0] used;
    logic       done;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [5:0] p, input logic [1:0] opi, input logic r,
                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] o,
                     input logic [1:0] c, input logic [2:0] x1, input logic [2:0] x2,
                     input logic [3:0] u, input logic d);
    vec_t v;
    v.pulses = p; v.opi = opi; v.req = r; v.a = a; v.b = b; v.op = o;
    v.cur = c; v.s1 = x1; v.s2 = x2; v.used = u; v.done = d;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input logic r, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] o, input logic [1:0] c,
                         input logic [2:0] x1, input logic [2:0] x2,
                         input logic [3:0] u, input logic d);
    chk({tag, ".req"},    {7'd0, req},    {7'd0, r});
    chk({tag, ".a_pos"},  {6'd0, a_pos},  {6'd0, a});
    chk({tag, ".b_pos"},  {6'd0, b_pos},  {6'd0, b});
    chk({tag, ".op"},     {6'd0, op},     {6'd0, o});
    chk({tag, ".cursor"}, {6'd0, cursor}, {6'd0, c});
    chk({tag, ".s1"},     {5'd0, s1},     {5'd0, x1});
    chk({tag, ".s2"},     {5'd0, s2},     {5'd0, x2});
    chk({tag, ".used"},   {4'd0, used},   {4'd0, u});
    chk({tag, ".done"},   {7'd0, done},   {7'd0, d});
  endtask

  task automatic apply(input logic [5:0] p, input logic [1:0] opi);
    {new_game, btn_clr, btn_sel, btn_next, frame_start, ack} = p;
    op_in = opi;
    @(posedge clk);
    #1;
  endtask

  // Reference model: selections as a list of picked positions, a pending flag,
  // and the consumed positions as a bit per slot.
  bit m_used[4];
  int m_cur, m_a, m_b, m_op, d_cur, d_s1, d_s2;
  int m_sel[$];
  bit m_pend;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += m_used[i];
    return n;
  endfunction

  function automatic int enc(input int i);
    return (m_sel.size() > i) ? 4 + m_sel[i] : 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_used[i] = 0;
    m_cur = 0; m_a = 0; m_b = 0; m_op = 0; d_cur = 0; d_s1 = 0; d_s2 = 0;
    m_sel.delete(); m_pend = 0;
  endtask

  task automatic m_step(input logic [5:0] p, input logic [1:0] opi);
    bit ng, cl, se, nx, fs, ak, dn;
    {ng, cl, se, nx, fs, ak} = p;
    dn = (m_count() == 3);
    if (fs) begin
      d_cur = m_cur; d_s1 = enc(0); d_s2 = enc(1);
    end
    if (ng) begin
      for (int i = 0; i < 4; i++) m_used[i] = 0;
      m_cur = 0; m_sel.delete(); m_pend = 0;
    end else if (m_pend) begin
      if (ak) begin
        m_used[m_a] = 1; m_sel.delete(); m_cur = m_b; m_pend = 0;
      end
    end else if (cl) begin
      m_sel.delete();
    end else if (se && !dn) begin
      if (m_sel.size() == 2) begin
        m_pend = 1; m_a = m_sel[0]; m_b = m_sel[1]; m_op = opi;
      end else if (m_sel.size() == 1 && m_sel[0] == m_cur) begin
        m_sel.delete();
      end else begin
        m_sel.push_back(m_cur);
      end
    end else if (nx && !dn) begin
      for (int k = 1; k <= 3; k++) begin
        if (!m_used[(m_cur + k) % 4]) begin
          m_cur = (m_cur + k) % 4;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [5:0] p;
    logic [1:0] o;

    rst_n = 1'b0;
    {new_game, btn_clr, btn_sel, btn_next, frame_start, ack} = '0;
    op_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_all("reset", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    //   pulses     opi req a  b  op cur s1 s2 used     done
    add(6'b000010, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // 0 frame
    add(6'b000100, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // 1 next -> 1
    add(6'b000100, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // 2 next -> 2
    add(6'b001000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // 3 sel s1=2
    add(6'b000100, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // 4 next -> 3
    add(6'b001000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // 5 sel s2=3
    add(6'b000010, 0, 0, 0, 0, 0, 3, 6, 7, 4'b0000, 0); // 6 frame
    add(6'b001000, 2, 1, 2, 3, 2, 3, 6, 7, 4'b0000, 0); // 7 request
    add(6'b000100, 0, 1, 2, 3, 2, 3, 6, 7, 4'b0000, 0); // 8 next ignored
    add(6'b010000, 0, 1, 2, 3, 2, 3, 6, 7, 4'b0000, 0); // 9 clr ignored
    add(6'b001000, 1, 1, 2, 3, 2, 3, 6, 7, 4'b0000, 0); // 10 sel ignored
    add(6'b000000, 0, 1, 2, 3, 2, 3, 6, 7, 4'b0000, 0); // 11 hold
    add(6'b000001, 0, 0, 2, 3, 2, 3, 6, 7, 4'b0100, 0); // 12 ack
    add(6'b000010, 0, 0, 2, 3, 2, 3, 0, 0, 4'b0100, 0); // 13 frame
    add(6'b000001, 0, 0, 2, 3, 2, 3, 0, 0, 4'b0100, 0); // 14 stray ack
    add(6'b000100, 0, 0, 2, 3, 2, 3, 0, 0, 4'b0100, 0); // 15 next -> 0
    add(6'b001000, 0, 0, 2, 3, 2, 3, 0, 0, 4'b0100, 0); // 16 sel s1=0
    add(6'b000010, 0, 0, 2, 3, 2, 0, 4, 0, 4'b0100, 0); // 17 frame
    add(6'b001000, 0, 0, 2, 3, 2, 0, 4, 0, 4'b0100, 0); // 18 deselect
    add(6'b000010, 0, 0, 2, 3, 2, 0, 0, 0, 4'b0100, 0); // 19 frame
    add(6'b001000, 0, 0, 2, 3, 2, 0, 0, 0, 4'b0100, 0); // 20 sel s1=0
    add(6'b000100, 0, 0, 2, 3, 2, 0, 0, 0, 4'b0100, 0); // 21 next -> 1
    add(6'b001000, 0, 0, 2, 3, 2, 0, 0, 0, 4'b0100, 0); // 22 sel s2=1
    add(6'b000010, 0, 0, 2, 3, 2, 1, 4, 5, 4'b0100, 0); // 23 frame
    add(6'b011000, 1, 0, 2, 3, 2, 1, 4, 5, 4'b0100, 0); // 24 clr+sel
    add(6'b000010, 0, 0, 2, 3, 2, 1, 0, 0, 4'b0100, 0); // 25 frame
    add(6'b001000, 0, 0, 2, 3, 2, 1, 0, 0, 4'b0100, 0); // 26 sel s1=1
    add(6'b000100, 0, 0, 2, 3, 2, 1, 0, 0, 4'b0100, 0); // 27 next -> 3
    add(6'b001000, 0, 0, 2, 3, 2, 1, 0, 0, 4'b0100, 0); // 28 sel s2=3
    add(6'b001000, 3, 1, 1, 3, 3, 1, 0, 0, 4'b0100, 0); // 29 request
    add(6'b000001, 0, 0, 1, 3, 3, 1, 0, 0, 4'b0110, 0); // 30 ack
    add(6'b000100, 0, 0, 1, 3, 3, 1, 0, 0, 4'b0110, 0); // 31 next -> 0
    add(6'b001000, 0, 0, 1, 3, 3, 1, 0, 0, 4'b0110, 0); // 32 sel s1=0
    add(6'b000100, 0, 0, 1, 3, 3, 1, 0, 0, 4'b0110, 0); // 33 next -> 3
    add(6'b001000, 0, 0, 1, 3, 3, 1, 0, 0, 4'b0110, 0); // 34 sel s2=3
    add(6'b001000, 0, 1, 0, 3, 0, 1, 0, 0, 4'b0110, 0); // 35 request
    add(6'b000001, 0, 0, 0, 3, 0, 1, 0, 0, 4'b0111, 1); // 36 ack, done
    add(6'b000100, 0, 0, 0, 3, 0, 1, 0, 0, 4'b0111, 1); // 37 next ignored
    add(6'b001000, 0, 0, 0, 3, 0, 1, 0, 0, 4'b0111, 1); // 38 sel ignored
    add(6'b000010, 0, 0, 0, 3, 0, 3, 0, 0, 4'b0111, 1); // 39 frame
    add(6'b100000, 0, 0, 0, 3, 0, 3, 0, 0, 4'b0000, 0); // 40 new game
    add(6'b001000, 0, 0, 0, 3, 0, 3, 0, 0, 4'b0000, 0); // 41 sel s1=0
    add(6'b000100, 0, 0, 0, 3, 0, 3, 0, 0, 4'b0000, 0); // 42 next -> 1
    add(6'b001000, 0, 0, 0, 3, 0, 3, 0, 0, 4'b0000, 0); // 43 sel s2=1
    add(6'b001000, 1, 1, 0, 1, 1, 3, 0, 0, 4'b0000, 0); // 44 request
    add(6'b100000, 0, 0, 0, 1, 1, 3, 0, 0, 4'b0000, 0); // 45 new game
    add(6'b000001, 0, 0, 0, 1, 1, 3, 0, 0, 4'b0000, 0); // 46 stray ack
    add(6'b000010, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0); // 47 frame
    add(6'b001000, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0); // 48 sel s1=0
    add(6'b000010, 0, 0, 0, 1, 1, 0, 4, 0, 4'b0000, 0); // 49 frame

    foreach (vt[i]) begin
      apply(vt[i].pulses, vt[i].opi);
      cmp_all($sformatf("vec%0d", i), vt[i].req, vt[i].a, vt[i].b, vt[i].op,
              vt[i].cur, vt[i].s1, vt[i].s2, vt[i].used, vt[i].done);
    end

    // Asynchronous reset between edges while a request is outstanding.
    apply(6'b000100, 0);
    apply(6'b001000, 0);
    apply(6'b000010, 0);
    apply(6'b001000, 3);
    cmp_all("pre_rst", 1, 0, 1, 3, 1, 4, 5, 4'b0000, 0);
    {new_game, btn_clr, btn_sel, btn_next, frame_start, ack} = '0;
    #3 rst_n = 1'b0;
    #1 cmp_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 cmp_all("post_rst", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // Randomized traffic against the reference model.
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      p[5] = ($urandom_range(0, 63) == 0);
      p[4] = ($urandom_range(0, 15) == 0);
      p[3] = ($urandom_range(0, 3) == 0);
      p[2] = ($urandom_range(0, 3) == 0);
      p[1] = ($urandom_range(0, 3) == 0);
      p[0] = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
      o    = 2'($urandom_range(0, 3));
      apply(p, o);
      m_step(p, o);
      cmp_all($sformatf("rnd%0d", n), m_pend, 2'(m_a), 2'(m_b), 2'(m_op),
              2'(d_cur), 3'(d_s1), 3'(d_s2),
              {m_used[3], m_used[2], m_used[1], m_used[0]}, (m_count() == 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
